// File: rtl/camera_pkg.sv
// Shared constants for the camera pipeline: main-FSM state codes (also decoded
// by the exposure-time controller), exposure limits and readout counter width.
package camera_pkg;

   localparam logic [1:0] S_IDLE     = 2'b00;
   localparam logic [1:0] S_EXPOSURE = 2'b01;
   localparam logic [1:0] S_READOUT  = 2'b10;

   localparam int EXP_MIN = 2;
   localparam int EXP_MAX = 30;

   // Holds 2L-1 = 31 at G_SETTLE = G_ADC_HIGH = 7, so the count never wraps
   localparam int RC_W = 5;

endpackage

// File: rtl/camera_readout_seq.sv
// Two-row readout sequencer: for each row, NRE low for settle + ADC pulse + hold,
// then one cycle released; o_Done marks the final count of the second row.
module camera_readout_seq
   import camera_pkg::*;
#(
   parameter int G_SETTLE   = 1,
   parameter int G_ADC_HIGH = 1
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Start,
   output logic o_NRE_1,
   output logic o_NRE_2,
   output logic o_ADC,
   output logic o_Done
);

   localparam int L = G_SETTLE + G_ADC_HIGH + 2;
   localparam logic [RC_W-1:0] C_L        = RC_W'(L);
   localparam logic [RC_W-1:0] C_LAST     = RC_W'(2 * L - 1);
   localparam logic [RC_W-1:0] C_SETTLE   = RC_W'(G_SETTLE);
   localparam logic [RC_W-1:0] C_ADC_END  = RC_W'(G_SETTLE + G_ADC_HIGH);
   localparam logic [RC_W-1:0] C_HOLD_END = RC_W'(L - 1);

   logic [RC_W-1:0] r_Rc;
   logic            r_Active;
   logic            w_Row2;
   logic [RC_W-1:0] w_Pos;
   logic            w_Low;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_Rc     <= '0;
         r_Active <= 1'b0;
      end else if (i_Start) begin
         r_Rc     <= '0;
         r_Active <= 1'b1;
      end else if (r_Active) begin
         if (r_Rc == C_LAST)
            r_Active <= 1'b0;
         else
            r_Rc <= r_Rc + 1'b1;
      end
   end

   // Position within the current row; both rows share one strobe pattern
   always_comb begin
      w_Row2  = (r_Rc >= C_L);
      w_Pos   = w_Row2 ? (r_Rc - C_L) : r_Rc;
      w_Low   = r_Active && (w_Pos < C_HOLD_END);
      o_NRE_1 = ~(w_Low & ~w_Row2);
      o_NRE_2 = ~(w_Low & w_Row2);
      o_ADC   = r_Active && (w_Pos >= C_SETTLE) && (w_Pos < C_ADC_END);
      o_Done  = r_Active && (r_Rc == C_LAST);
   end

endmodule

// File: rtl/camera_main_fsm.sv
// Top-level camera sequencer IDLE -> EXPOSURE -> READOUT -> IDLE; owns the
// state register and Init edge detect, delegates row timing to the readout sequencer.
module camera_main_fsm
   import camera_pkg::*;
#(
   parameter int G_SETTLE   = 1,
   parameter int G_ADC_HIGH = 1
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Init,
   input  logic [4:0] i_count_time,
   output logic [1:0] o_Main_FSM,
   output logic       o_Erase,
   output logic       o_Expose,
   output logic       o_NRE_1,
   output logic       o_NRE_2,
   output logic       o_ADC,
   output logic       o_Frame_done
);

   logic [1:0] r_State;
   logic [1:0] w_Next;
   logic       r_Init_Prev;
   logic       r_Frame_done;
   logic       w_Start;
   logic       w_Seq_Start;
   logic       w_NRE_1;
   logic       w_NRE_2;
   logic       w_ADC;
   logic       w_Done;

   assign w_Start     = i_Init & ~r_Init_Prev;
   assign w_Seq_Start = (r_State == S_EXPOSURE) && (i_count_time == 5'd0);

   camera_readout_seq #(
      .G_SETTLE   (G_SETTLE),
      .G_ADC_HIGH (G_ADC_HIGH)
   ) u_readout (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Start (w_Seq_Start),
      .o_NRE_1 (w_NRE_1),
      .o_NRE_2 (w_NRE_2),
      .o_ADC   (w_ADC),
      .o_Done  (w_Done)
   );

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State      <= S_IDLE;
         r_Init_Prev  <= 1'b0;
         r_Frame_done <= 1'b0;
      end else begin
         r_State      <= w_Next;
         r_Init_Prev  <= i_Init;
         r_Frame_done <= (r_State == S_READOUT) && w_Done;
      end
   end

   // Starts outside IDLE are dropped; encoding 11 falls back to IDLE
   always_comb begin
      w_Next = S_IDLE;
      case (r_State)
         S_IDLE:     w_Next = w_Start ? S_EXPOSURE : S_IDLE;
         S_EXPOSURE: w_Next = (i_count_time == 5'd0) ? S_READOUT : S_EXPOSURE;
         S_READOUT:  w_Next = w_Done ? S_IDLE : S_READOUT;
         default:    w_Next = S_IDLE;
      endcase
   end

   always_comb begin
      o_Main_FSM   = r_State;
      o_Expose     = (r_State == S_EXPOSURE);
      o_Erase      = (r_State != S_EXPOSURE) && (r_State != S_READOUT);
      o_NRE_1      = (r_State == S_READOUT) ? w_NRE_1 : 1'b1;
      o_NRE_2      = (r_State == S_READOUT) ? w_NRE_2 : 1'b1;
      o_ADC        = (r_State == S_READOUT) ? w_ADC : 1'b0;
      o_Frame_done = r_Frame_done;
   end

endmodule

// File: tb/tb_camera_main_fsm.sv
// Directed bench for camera_main_fsm: default-parameter instance driven from
// cycle tables, plus a G_SETTLE=2 / G_ADC_HIGH=3 instance checked by row pattern.
module tb_camera_main_fsm;

   logic       clk = 1'b0;
   logic       rst1, init1, rst2, init2;
   logic [4:0] cnt1, cnt2, T1, T2;
   logic [1:0] fsm1, fsm2;
   logic       er1, ex1, n11, n21, adc1, dn1;
   logic       er2, ex2, n12, n22, adc2, dn2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   camera_main_fsm dut (
      .i_Clock (clk), .i_Reset (rst1), .i_Init (init1), .i_count_time (cnt1),
      .o_Main_FSM (fsm1), .o_Erase (er1), .o_Expose (ex1), .o_NRE_1 (n11),
      .o_NRE_2 (n21), .o_ADC (adc1), .o_Frame_done (dn1)
   );

   camera_main_fsm #(.G_SETTLE(2), .G_ADC_HIGH(3)) dut2 (
      .i_Clock (clk), .i_Reset (rst2), .i_Init (init2), .i_count_time (cnt2),
      .o_Main_FSM (fsm2), .o_Erase (er2), .o_Expose (ex2), .o_NRE_1 (n12),
      .o_NRE_2 (n22), .o_ADC (adc2), .o_Frame_done (dn2)
   );

   // Exposure-time controller models: reload T outside EXPOSURE, count down inside
   always @(posedge clk) begin
      if (fsm1 == 2'b01) begin
         if (cnt1 != 5'd0) cnt1 <= cnt1 - 5'd1;
      end else
         cnt1 <= T1;
      if (fsm2 == 2'b01) begin
         if (cnt2 != 5'd0) cnt2 <= cnt2 - 5'd1;
      end else
         cnt2 <= T2;
   end

   // {fsm[1:0], erase, expose, nre1, nre2, adc, frame_done}
   localparam logic [7:0] IDLE = 8'b00_1_0_1_1_0_0;
   localparam logic [7:0] EXPO = 8'b01_0_1_1_1_0_0;
   localparam logic [7:0] DONE = 8'b00_1_0_1_1_0_1;

   typedef struct {
      logic       rst;
      logic       init;
      logic [7:0] exp;
   } vec_t;

   vec_t rst_tbl[4];
   vec_t frame_tbl[16];

   function automatic logic [7:0] obs1();
      return {fsm1, er1, ex1, n11, n21, adc1, dn1};
   endfunction

   function automatic logic [7:0] obs2();
      return {fsm2, er2, ex2, n12, n22, adc2, dn2};
   endfunction

   task automatic apply(input logic rst, input logic init, input logic [7:0] exp,
                        input string nm);
      logic [7:0] act;
      @(negedge clk);
      rst1  = rst;
      init1 = init;
      @(posedge clk);
      #1;
      act = obs1();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic check2(input logic [7:0] exp, input string nm);
      logic [7:0] act;
      act = obs2();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic got;
      int   exp_cycles;
      logic [7:0] e;
      logic nre1_e, nre2_e, adc_e;

      rst1 = 1'b1; init1 = 1'b0; T1 = 5'd5; cnt1 = 5'd5;
      rst2 = 1'b1; init2 = 1'b0; T2 = 5'd2; cnt2 = 5'd2;

      rst_tbl[0] = '{1'b1, 1'b0, IDLE};
      rst_tbl[1] = '{1'b1, 1'b0, IDLE};
      rst_tbl[2] = '{1'b0, 1'b0, IDLE};
      rst_tbl[3] = '{1'b0, 1'b0, IDLE};

      for (int i = 0; i < 6; i++) frame_tbl[i] = '{1'b0, 1'b1, EXPO};
      frame_tbl[6]  = '{1'b0, 1'b1, 8'b10_0_0_0_1_0_0};  // rc0 NRE_1 low
      frame_tbl[7]  = '{1'b0, 1'b1, 8'b10_0_0_0_1_1_0};  // rc1 ADC
      frame_tbl[8]  = '{1'b0, 1'b1, 8'b10_0_0_0_1_0_0};  // rc2 hold
      frame_tbl[9]  = '{1'b0, 1'b1, 8'b10_0_0_1_1_0_0};  // rc3 released
      frame_tbl[10] = '{1'b0, 1'b1, 8'b10_0_0_1_0_0_0};  // rc4 NRE_2 low
      frame_tbl[11] = '{1'b0, 1'b1, 8'b10_0_0_1_0_1_0};  // rc5 ADC
      frame_tbl[12] = '{1'b0, 1'b1, 8'b10_0_0_1_0_0_0};  // rc6 hold
      frame_tbl[13] = '{1'b0, 1'b1, 8'b10_0_0_1_1_0_0};  // rc7 released
      frame_tbl[14] = '{1'b0, 1'b1, DONE};
      frame_tbl[15] = '{1'b0, 1'b1, IDLE};

      for (int i = 0; i < 4; i++)
         apply(rst_tbl[i].rst, rst_tbl[i].init, rst_tbl[i].exp, $sformatf("reset[%0d]", i));

      // Nominal frame with Init held high throughout
      for (int i = 0; i < 16; i++)
         apply(frame_tbl[i].rst, frame_tbl[i].init, frame_tbl[i].exp, $sformatf("frame[%0d]", i));
      for (int i = 0; i < 24; i++)
         apply(1'b0, 1'b1, IDLE, $sformatf("held_init[%0d]", i));
      apply(1'b0, 1'b0, IDLE, "init_drop");

      // Zero exposure: a single EXPOSURE cycle
      T1 = 5'd0;
      apply(1'b0, 1'b1, EXPO, "zexp_enter");
      apply(1'b0, 1'b1, 8'b10_0_0_0_1_0_0, "zexp_readout");
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         #1;
         if (dn1) got = 1'b1;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL zexp_done: got frame_done=0 expected 1 within 20 cycles");
      end

      // Mid-frame reset at rc=5, then a clean frame
      T1 = 5'd5;
      apply(1'b0, 1'b0, IDLE, "pre_rst_idle");
      for (int i = 0; i < 12; i++)
         apply(frame_tbl[i].rst, frame_tbl[i].init, frame_tbl[i].exp, $sformatf("prerst[%0d]", i));
      apply(1'b1, 1'b0, IDLE, "midframe_reset");
      apply(1'b0, 1'b0, IDLE, "post_reset_idle");
      for (int i = 0; i < 16; i++)
         apply(frame_tbl[i].rst, frame_tbl[i].init, frame_tbl[i].exp, $sformatf("clean[%0d]", i));

      // G_SETTLE=2, G_ADC_HIGH=3 instance, T=2
      @(negedge clk);
      rst2 = 1'b0; init2 = 1'b0;
      @(posedge clk);
      #1;
      check2(IDLE, "p2_idle");
      @(negedge clk);
      init2 = 1'b1;
      exp_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (fsm2 == 2'b01) exp_cycles++;
         else break;
      end
      checks++;
      if (exp_cycles != 3) begin
         failures++;
         $display("FAIL p2_expose_len: got %0d expected 3", exp_cycles);
      end
      for (int rc = 0; rc < 14; rc++) begin
         if (rc > 0) begin
            @(posedge clk);
            #1;
         end
         nre1_e = !(rc <= 5);
         nre2_e = !(rc >= 7 && rc <= 12);
         adc_e  = (rc >= 2 && rc <= 4) || (rc >= 9 && rc <= 11);
         e = {2'b10, 1'b0, 1'b0, nre1_e, nre2_e, adc_e, 1'b0};
         check2(e, $sformatf("p2_rc%0d", rc));
         checks++;
         if (!n12 && !n22) begin
            failures++;
            $display("FAIL p2_nre_overlap rc%0d: got both low expected at most one", rc);
         end
      end
      @(posedge clk);
      #1;
      check2(DONE, "p2_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
